// File: rtl/sp_stack_sequencer.sv
// Stack-operation sequencer: drives SP update and memory word transfers
// for PUSH/POP/CALL/RET/INT/RTI while tracking stack occupancy.
module sp_stack_sequencer #(
  parameter int STACK_WORDS = 1024,
  parameter int DEPTH_W     = 11
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               Op_Valid,
  input  logic [2:0]         Op_Code,
  output logic               Op_Ready,
  output logic [1:0]         SP_OP,
  output logic               SP_Commit,
  output logic               Mem_Req,
  output logic               Mem_Write,
  output logic [1:0]         Mem_Sel,
  input  logic               Mem_Ack,
  output logic               Busy,
  output logic               Done,
  output logic               Err_Overflow,
  output logic               Err_Underflow,
  output logic [DEPTH_W-1:0] Depth
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [1:0] SEL_REG   = 2'd0;
  localparam logic [1:0] SEL_PC_HI = 2'd1;
  localparam logic [1:0] SEL_PC_LO = 2'd2;
  localparam logic [1:0] SEL_FLAGS = 2'd3;

  localparam logic [DEPTH_W+1:0] CAP =
    (DEPTH_W+2)'(STACK_WORDS);

  state_t            state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        last_q, last_d;
  logic              wr_q, wr_d;
  logic [3:0][1:0]   seq_q, seq_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [1:0]        dec_n;
  logic              dec_wr;
  logic [3:0][1:0]   dec_seq;
  logic [DEPTH_W+1:0] depth_x;
  logic [DEPTH_W+1:0] n_x;
  logic              over;
  logic              under;

  // Decode the op code into word count, direction and word order
  always_comb begin
    dec_n   = 2'd0;
    dec_wr  = 1'b0;
    dec_seq = '0;
    unique case (1'b1)
      (Op_Code == 3'b001): begin
        dec_n      = 2'd1;
        dec_wr     = 1'b1;
        dec_seq[0] = SEL_REG;
      end
      (Op_Code == 3'b010): begin
        dec_n      = 2'd1;
        dec_seq[0] = SEL_REG;
      end
      (Op_Code == 3'b011): begin
        dec_n      = 2'd2;
        dec_wr     = 1'b1;
        dec_seq[0] = SEL_PC_HI;
        dec_seq[1] = SEL_PC_LO;
      end
      (Op_Code == 3'b100): begin
        dec_n      = 2'd2;
        dec_seq[0] = SEL_PC_LO;
        dec_seq[1] = SEL_PC_HI;
      end
      (Op_Code == 3'b101): begin
        dec_n      = 2'd3;
        dec_wr     = 1'b1;
        dec_seq[0] = SEL_PC_HI;
        dec_seq[1] = SEL_PC_LO;
        dec_seq[2] = SEL_FLAGS;
      end
      (Op_Code == 3'b110): begin
        dec_n      = 2'd3;
        dec_seq[0] = SEL_FLAGS;
        dec_seq[1] = SEL_PC_LO;
        dec_seq[2] = SEL_PC_HI;
      end
      default: ;
    endcase
  end

  assign depth_x = {2'b00, depth_q};
  assign n_x     = {{DEPTH_W{1'b0}}, dec_n};
  assign over    = dec_wr && ((depth_x + n_x) > CAP);
  assign under   = !dec_wr && (depth_x < n_x);

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    depth_d       = depth_q;
    idx_d         = idx_q;
    last_d        = last_q;
    wr_d          = wr_q;
    seq_d         = seq_q;
    ovf_d         = ovf_q;
    unf_d         = unf_q;
    Op_Ready      = 1'b0;
    Busy          = 1'b0;
    Mem_Req       = 1'b0;
    Mem_Write     = 1'b0;
    Mem_Sel       = 2'd0;
    SP_OP         = 2'b00;
    Done          = 1'b0;
    Err_Overflow  = 1'b0;
    Err_Underflow = 1'b0;
    unique case (state_q)
      IDLE: begin
        Op_Ready = 1'b1;
        if (Op_Valid) begin
          wr_d   = dec_wr;
          seq_d  = dec_seq;
          last_d = dec_n - 2'd1;
          idx_d  = 2'd0;
          ovf_d  = over;
          unf_d  = under;
          if (dec_n == 2'd0 || over || under)
            state_d = FIN;
          else
            state_d = XFER;
        end
      end
      XFER: begin
        Busy      = 1'b1;
        Mem_Req   = 1'b1;
        Mem_Write = wr_q;
        Mem_Sel   = seq_q[idx_q];
        SP_OP     = wr_q ? 2'b10 : 2'b11;
        if (Mem_Ack) begin
          depth_d = wr_q ? depth_q + 1'b1
                         : depth_q - 1'b1;
          if (idx_q == last_q)
            state_d = FIN;
          else
            idx_d = idx_q + 2'd1;
        end
      end
      FIN: begin
        Busy          = 1'b1;
        Done          = 1'b1;
        Err_Overflow  = ovf_q;
        Err_Underflow = unf_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A word aborted by reset must not commit the SP result
  assign SP_Commit = Mem_Req & Mem_Ack & Reset;
  assign Depth     = depth_q;

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= IDLE;
      depth_q <= '0;
      idx_q   <= 2'd0;
      last_q  <= 2'd0;
      wr_q    <= 1'b0;
      seq_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      seq_q   <= seq_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule

// File: tb/tb_sp_stack_sequencer.sv
// Bench for sp_stack_sequencer: transaction-level model plus
// directed stack-op scenarios on a 4-word stack.
module tb_sp_stack_sequencer;

  localparam int SW = 4;
  localparam int DW = 3;

  logic          CLK = 1'b0;
  logic          Reset = 1'b0;
  logic          Op_Valid = 1'b0;
  logic [2:0]    Op_Code = 3'b000;
  logic          Op_Ready;
  logic [1:0]    SP_OP;
  logic          SP_Commit;
  logic          Mem_Req;
  logic          Mem_Write;
  logic [1:0]    Mem_Sel;
  logic          Mem_Ack = 1'b1;
  logic          Busy;
  logic          Done;
  logic          Err_Overflow;
  logic          Err_Underflow;
  logic [DW-1:0] Depth;

  sp_stack_sequencer #(
    .STACK_WORDS(SW),
    .DEPTH_W(DW)
  ) dut (
    .CLK(CLK),
    .Reset(Reset),
    .Op_Valid(Op_Valid),
    .Op_Code(Op_Code),
    .Op_Ready(Op_Ready),
    .SP_OP(SP_OP),
    .SP_Commit(SP_Commit),
    .Mem_Req(Mem_Req),
    .Mem_Write(Mem_Write),
    .Mem_Sel(Mem_Sel),
    .Mem_Ack(Mem_Ack),
    .Busy(Busy),
    .Done(Done),
    .Err_Overflow(Err_Overflow),
    .Err_Underflow(Err_Underflow),
    .Depth(Depth)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t act=%0h exp=%0h",
               nm, $time, act, exp);
    end
  endtask

  // Model: expected per-cycle items (words, then a done item)
  typedef struct {
    bit       done;
    bit [1:0] sel;
    bit       wr;
    bit       ovf;
    bit       unf;
  } item_t;

  item_t q[$];
  int    mdepth = 0;
  bit    cmp_en = 0;

  function automatic void build(input bit [2:0] c);
    int    push_seq[$];
    int    words[$];
    bit    wr;
    item_t it;
    wr = 0;
    push_seq = {};
    case (c)
      3'd1, 3'd2: push_seq = {0};
      3'd3, 3'd4: push_seq = {1, 2};
      3'd5, 3'd6: push_seq = {1, 2, 3};
      default:    push_seq = {};
    endcase
    wr = (c == 3'd1 || c == 3'd3 || c == 3'd5);
    words = {};
    foreach (push_seq[i])
      if (wr) words.push_back(push_seq[i]);
      else    words.push_front(push_seq[i]);
    it = '{done: 1, sel: 0, wr: 0, ovf: 0, unf: 0};
    if (words.size() == 0) begin
      q.push_back(it);
    end else if (wr && mdepth + words.size() > SW) begin
      it.ovf = 1;
      q.push_back(it);
    end else if (!wr && mdepth < words.size()) begin
      it.unf = 1;
      q.push_back(it);
    end else begin
      foreach (words[i])
        q.push_back('{done: 0, sel: 2'(words[i]),
                      wr: wr, ovf: 0, unf: 0});
      q.push_back(it);
    end
  endfunction

  // Model advance on each rising edge
  always @(posedge CLK) begin
    if (!Reset) begin
      q.delete();
      mdepth = 0;
    end else if (q.size() == 0) begin
      if (Op_Valid) build(Op_Code);
    end else if (q[0].done) begin
      void'(q.pop_front());
    end else if (Mem_Ack) begin
      mdepth += q[0].wr ? 1 : -1;
      void'(q.pop_front());
    end
  end

  // Every-cycle output comparison against the model
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("depth", 32'(Depth), 32'(mdepth));
      if (q.size() == 0) begin
        chk("idle_ready", 32'(Op_Ready), 1);
        chk("idle_busy", 32'(Busy), 0);
        chk("idle_req", 32'(Mem_Req), 0);
        chk("idle_spop", 32'(SP_OP), 0);
        chk("idle_commit", 32'(SP_Commit), 0);
        chk("idle_done", 32'(Done), 0);
        chk("idle_err",
            32'({Err_Overflow, Err_Underflow}), 0);
      end else if (!q[0].done) begin
        chk("xfer_ready", 32'(Op_Ready), 0);
        chk("xfer_busy", 32'(Busy), 1);
        chk("xfer_req", 32'(Mem_Req), 1);
        chk("xfer_wr", 32'(Mem_Write), 32'(q[0].wr));
        chk("xfer_sel", 32'(Mem_Sel), 32'(q[0].sel));
        chk("xfer_spop", 32'(SP_OP),
            q[0].wr ? 32'd2 : 32'd3);
        chk("xfer_commit", 32'(SP_Commit),
            32'(Mem_Ack & Reset));
        chk("xfer_done", 32'(Done), 0);
      end else begin
        chk("fin_ready", 32'(Op_Ready), 0);
        chk("fin_busy", 32'(Busy), 1);
        chk("fin_done", 32'(Done), 1);
        chk("fin_req", 32'(Mem_Req), 0);
        chk("fin_spop", 32'(SP_OP), 0);
        chk("fin_commit", 32'(SP_Commit), 0);
        chk("fin_ovf", 32'(Err_Overflow), 32'(q[0].ovf));
        chk("fin_unf", 32'(Err_Underflow), 32'(q[0].unf));
      end
    end
  end

  int commit_cnt = 0;
  int done_cnt = 0;
  int req_cnt = 0;

  always @(negedge CLK) begin
    if (SP_Commit) commit_cnt++;
    if (Done) done_cnt++;
    if (Mem_Req) req_cnt++;
  end

  // Memory acknowledge with a programmable stall on the first word
  int stall_left = 0;
  always begin
    @(posedge CLK);
    #1;
    Mem_Ack = (stall_left == 0);
    if (Mem_Req && stall_left > 0) stall_left--;
  end

  task automatic run_op(input string nm,
                        input bit [2:0] code,
                        input int stall,
                        input bit toggle,
                        input int exp_lat,
                        input int exp_depth,
                        input int exp_words,
                        input bit [1:0] exp_err);
    int       lat;
    bit [1:0] errs;
    lat = 0;
    errs = 2'b00;
    @(negedge CLK);
    stall_left = stall;
    Op_Valid = 1'b1;
    Op_Code = code;
    commit_cnt = 0;
    done_cnt = 0;
    req_cnt = 0;
    @(posedge CLK);
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (Done) begin
        lat = i;
        errs = {Err_Overflow, Err_Underflow};
        Op_Valid = 1'b0;
        break;
      end
      Op_Valid = toggle ? 1'($urandom) : 1'b0;
      Op_Code = toggle ? 3'($urandom) : code;
    end
    Op_Valid = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_depth"}, 32'(Depth), 32'(exp_depth));
    chk({nm, "_commits"}, 32'(commit_cnt), 32'(exp_words));
    chk({nm, "_dones"}, 32'(done_cnt), 1);
    chk({nm, "_errs"}, 32'(errs), 32'(exp_err));
    if (exp_err != 2'b00)
      chk({nm, "_no_req"}, 32'(req_cnt), 0);
  endtask

  initial begin
    Reset = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    cmp_en = 1;
    chk("rst_depth", 32'(Depth), 0);
    chk("rst_ready", 32'(Op_Ready), 1);
    chk("rst_spop", 32'(SP_OP), 0);
    Reset = 1'b1;

    run_op("call", 3'b011, 0, 0, 3, 2, 2, 2'b00);
    run_op("rti_unf", 3'b110, 0, 0, 1, 2, 0, 2'b01);
    run_op("ret", 3'b100, 0, 0, 3, 0, 2, 2'b00);
    run_op("int_stall", 3'b101, 4, 0, 8, 3, 3, 2'b00);
    run_op("push_full", 3'b001, 0, 0, 2, 4, 1, 2'b00);
    run_op("call_ovf", 3'b011, 0, 0, 1, 4, 0, 2'b10);
    run_op("pop", 3'b010, 0, 0, 2, 3, 1, 2'b00);
    run_op("pop2", 3'b010, 0, 0, 2, 2, 1, 2'b00);

    // Reset lands on the second word of a CALL
    @(negedge CLK);
    stall_left = 0;
    Op_Valid = 1'b1;
    Op_Code = 3'b011;
    commit_cnt = 0;
    @(posedge CLK);
    #1;
    Op_Valid = 1'b0;
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    @(posedge CLK);
    #1;
    Reset = 1'b1;
    @(negedge CLK);
    chk("abort_req", 32'(Mem_Req), 0);
    chk("abort_spop", 32'(SP_OP), 0);
    chk("abort_depth", 32'(Depth), 0);
    chk("abort_ready", 32'(Op_Ready), 1);
    chk("abort_commits", 32'(commit_cnt), 1);

    run_op("nop7", 3'b111, 0, 0, 1, 0, 0, 2'b00);
    run_op("nop0", 3'b000, 0, 0, 1, 0, 0, 2'b00);
    run_op("pop_empty", 3'b010, 0, 0, 1, 0, 0, 2'b01);
    run_op("push_tog", 3'b001, 0, 1, 2, 1, 1, 2'b00);
    run_op("int_tog", 3'b101, 2, 1, 6, 4, 3, 2'b00);
    run_op("rti_tog", 3'b110, 0, 1, 4, 1, 3, 2'b00);

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
